conv2_frame_scheduler: RTL and testbench
========================================

Name: conv2_frame_scheduler

Overview:
- Sequences one 13x13x3 feature-map frame from the pooled-feature buffer into the conv2 engine.
- Reads buffer words in raster order and drives conv2 `data_in`/`data_in_valid`, throttled by conv2 `c2_ready`.
- Collects conv2 `data_out` beats into the result buffer.
- Signals frame completion, or a stall error via watchdog; sits between layer-1 pooling control and the conv2 datapath.

Parameters:
- IMG_W, 13, input frame width in pixels
- IMG_H, 13, input frame height in pixels
- KSZ, 3, conv kernel size
- OUT_CH, 3, conv2 output channels emitted per window
- DATA_W, 96, input word width (3 channels x 32 bit)
- OUT_W, 16, conv2 result width
- RD_AW, 8, feature-buffer address width
- WR_AW, 9, result-buffer address width
- WDOG, 1023, max idle cycles without input issue or output beat before error

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start pulse
- busy  out  1  high from accepted start until done/err
- done  out  1  one-cycle pulse: frame completed normally
- err  out  1  one-cycle pulse: watchdog expired
- fb_rd_en  out  1  feature-buffer read enable
- fb_rd_addr  out  RD_AW  feature-buffer read address
- fb_rd_data  in  DATA_W  feature-buffer data, valid 1 cycle after fb_rd_en
- c2_ready  in  1  conv2 can accept input this cycle
- c2_data_in  out  DATA_W  word to conv2
- c2_data_in_valid  out  1  conv2 input strobe
- c2_data_out  in  OUT_W  conv2 result
- c2_data_out_valid  in  1  conv2 result strobe
- res_we  out  1  result-buffer write enable
- res_addr  out  WR_AW  result-buffer write address
- res_data  out  OUT_W  result-buffer write data
- out_count  out  WR_AW  results captured so far in current frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; all counters 0.
- Constants:
  - N_IN = IMG_W*IMG_H = 169
  - N_OUT = (IMG_W-KSZ+1)*(IMG_H-KSZ+1)*OUT_CH = 363
- FSM states: IDLE, FEED, DRAIN, FINISH.
- IDLE:
  - start=1 -> FEED; clear in_cnt, out_cnt, wdog; busy=1 next cycle.
  - start while not IDLE is ignored.
- FEED:
  - Each cycle with c2_ready=1 and in_cnt<N_IN: fb_rd_en=1, fb_rd_addr=in_cnt, in_cnt++.
  - Issue stage registered: c2_data_in_valid asserts exactly 1 cycle after fb_rd_en.
  - c2_data_in = fb_rd_data on that cycle; 0 otherwise.
  - An issued read is always delivered even if c2_ready falls in between (conv2 provides one word of slack).
  - When the last read issues (in_cnt reaches N_IN) -> DRAIN.
- DRAIN: wait for out_cnt==N_OUT -> FINISH.
- Output capture (FEED and DRAIN):
  - On c2_data_out_valid=1: res_we=1, res_addr=out_cnt, res_data=c2_data_out, out_cnt++ (all registered, 1-cycle latency).
  - Beats beyond N_OUT are dropped: res_we stays 0, out_cnt saturates.
  - Beats in IDLE/FINISH are ignored.
- FINISH: done=1 for one cycle, busy=0, -> IDLE.
- Watchdog:
  - In FEED/DRAIN, wdog increments on cycles with neither fb_rd_en nor a captured output beat; resets to 0 on either.
  - wdog==WDOG -> err=1 for one cycle, busy=0, -> IDLE; results written so far are retained.
- Same-cycle events: last input issue and an output beat in the same cycle are both processed; out_cnt reaching N_OUT in the same cycle FEED ends goes FEED -> DRAIN -> FINISH on consecutive cycles, with no skip.
- Widths: counters are sized by parameter; out_count mirrors out_cnt.
- Async reset mid-frame aborts immediately with no done/err pulse; the in-flight c2_data_in_valid is squashed.

Decomposition:
- Shared package `conv_sched_pkg`:
  - FSM state enum
  - N_IN/N_OUT derivation function
  - default geometry constants (13, 3, 3), reused by the conv1/conv3 schedulers
- One natural sub-module: `sched_watchdog` (idle-cycle counter with clear, expire pulse).

Test Plan:
- Nominal: start, c2_ready=1 constantly, model conv2 returns 363 beats -> 169 reads at addr 0..168 on consecutive cycles, c2_data_in_valid lags fb_rd_en by 1, res_addr 0..362, done pulse once, busy low after.
- Backpressure: c2_ready toggles 1/0 each cycle -> reads only on ready cycles, no address skipped or repeated, 169 valid words total, done still asserted.
- Ready drop with read in flight: c2_ready falls the cycle after fb_rd_en -> that word still delivered with c2_data_in_valid=1; no further reads until ready returns.
- Watchdog: model stops output after 100 beats -> err pulse exactly WDOG+1 cycles after the last beat, out_count=100, done never asserted.
- Excess output and stray start: model emits 370 beats and start pulses mid-frame -> res_we exactly 363 times, out_count=363, start ignored.
- Reset mid-frame: rst_n low at in_cnt=50 -> all outputs 0 asynchronously, no done/err pulse, next start restarts at addr 0.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// rtl/conv_sched_pkg.sv - shared FSM states and frame geometry for the conv-layer schedulers
package conv_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FEED   = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_FINISH = 2'd3
   } sched_state_e;

   localparam int DEF_IMG_W  = 13;
   localparam int DEF_IMG_H  = 13;
   localparam int DEF_KSZ    = 3;
   localparam int DEF_OUT_CH = 3;

   function automatic int calc_n_in(input int img_w, input int img_h);
      return img_w * img_h;
   endfunction

   // Valid (no padding) convolution: one result per window per output channel.
   function automatic int calc_n_out(input int img_w, input int img_h,
                                     input int ksz, input int out_ch);
      return (img_w - ksz + 1) * (img_h - ksz + 1) * out_ch;
   endfunction

endpackage

// File: rtl/conv2_frame_scheduler_if.sv
// rtl/conv2_frame_scheduler_if.sv - control, feature-buffer, conv2 and result-buffer signal bundle
interface conv2_frame_scheduler_if #(
   parameter int DATA_W = 96,
   parameter int OUT_W  = 16,
   parameter int RD_AW  = 8,
   parameter int WR_AW  = 9
);

   logic              start;
   logic              busy;
   logic              done;
   logic              err;
   logic              fb_rd_en;
   logic [RD_AW-1:0]  fb_rd_addr;
   logic [DATA_W-1:0] fb_rd_data;
   logic              c2_ready;
   logic [DATA_W-1:0] c2_data_in;
   logic              c2_data_in_valid;
   logic [OUT_W-1:0]  c2_data_out;
   logic              c2_data_out_valid;
   logic              res_we;
   logic [WR_AW-1:0]  res_addr;
   logic [OUT_W-1:0]  res_data;
   logic [WR_AW-1:0]  out_count;

   modport sched (
      input  start, fb_rd_data, c2_ready, c2_data_out, c2_data_out_valid,
      output busy, done, err, fb_rd_en, fb_rd_addr, c2_data_in, c2_data_in_valid,
             res_we, res_addr, res_data, out_count
   );

   modport env (
      output start, fb_rd_data, c2_ready, c2_data_out, c2_data_out_valid,
      input  busy, done, err, fb_rd_en, fb_rd_addr, c2_data_in, c2_data_in_valid,
             res_we, res_addr, res_data, out_count
   );

endinterface

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - idle-cycle counter; expires after LIMIT cycles without a kick
module sched_watchdog #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic kick_i,
   output logic expire_o
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] cnt_q, cnt_d;

   // Held at zero while disabled so every frame starts from a clean count.
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i || kick_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIMIT_C) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LIMIT_C);

endmodule

// File: rtl/conv2_frame_scheduler.sv
// rtl/conv2_frame_scheduler.sv - streams one pooled frame into conv2 and collects its results
module conv2_frame_scheduler
   import conv_sched_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int KSZ    = DEF_KSZ,
   parameter int OUT_CH = DEF_OUT_CH,
   parameter int DATA_W = 96,
   parameter int OUT_W  = 16,
   parameter int RD_AW  = 8,
   parameter int WR_AW  = 9,
   parameter int WDOG   = 1023
) (
   input logic                     clk,
   input logic                     rst_n,
   conv2_frame_scheduler_if.sched  bus
);

   localparam int N_IN  = calc_n_in(IMG_W, IMG_H);
   localparam int N_OUT = calc_n_out(IMG_W, IMG_H, KSZ, OUT_CH);

   localparam logic [RD_AW-1:0] N_IN_C    = RD_AW'(N_IN);
   localparam logic [RD_AW-1:0] LAST_IN_C = RD_AW'(N_IN - 1);
   localparam logic [WR_AW-1:0] N_OUT_C   = WR_AW'(N_OUT);

   sched_state_e      state_q, state_d;
   logic [RD_AW-1:0]  in_cnt_q, in_cnt_d;
   logic [WR_AW-1:0]  out_cnt_q, out_cnt_d;
   logic              issue_q;
   logic              res_we_q;
   logic [WR_AW-1:0]  res_addr_q;
   logic [OUT_W-1:0]  res_data_q;

   logic active;
   logic rd_fire;
   logic cap;
   logic wd_expire;

   assign active  = (state_q == ST_FEED) || (state_q == ST_DRAIN);
   assign rd_fire = (state_q == ST_FEED) && bus.c2_ready && (in_cnt_q < N_IN_C);
   // Beats past the last expected result are dropped, so out_cnt saturates.
   assign cap     = active && bus.c2_data_out_valid && (out_cnt_q < N_OUT_C);

   sched_watchdog #(
      .LIMIT (WDOG)
   ) u_wdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (active),
      .kick_i   (rd_fire || cap),
      .expire_o (wd_expire)
   );

   always_comb begin
      state_d   = state_q;
      in_cnt_d  = in_cnt_q;
      out_cnt_d = out_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d   = ST_FEED;
               in_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         ST_FEED: begin
            if (rd_fire) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == LAST_IN_C) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (out_cnt_q == N_OUT_C) begin
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (cap) begin
         out_cnt_d = out_cnt_q + 1'b1;
      end
      if (wd_expire) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         in_cnt_q   <= '0;
         out_cnt_q  <= '0;
         issue_q    <= 1'b0;
         res_we_q   <= 1'b0;
         res_addr_q <= '0;
         res_data_q <= '0;
      end else begin
         state_q    <= state_d;
         in_cnt_q   <= in_cnt_d;
         out_cnt_q  <= out_cnt_d;
         issue_q    <= rd_fire;
         res_we_q   <= cap;
         res_addr_q <= cap ? out_cnt_q : '0;
         res_data_q <= cap ? bus.c2_data_out : '0;
      end
   end

   // Read data lands one cycle after the read; conv2 absorbs it even if ready has dropped.
   assign bus.c2_data_in_valid = issue_q;
   assign bus.c2_data_in       = issue_q ? bus.fb_rd_data : '0;
   assign bus.fb_rd_en         = rd_fire;
   assign bus.fb_rd_addr       = rd_fire ? in_cnt_q : '0;

   assign bus.busy      = active && !wd_expire;
   assign bus.done      = (state_q == ST_FINISH);
   assign bus.err       = wd_expire;
   assign bus.res_we    = res_we_q;
   assign bus.res_addr  = res_addr_q;
   assign bus.res_data  = res_data_q;
   assign bus.out_count = out_cnt_q;

endmodule

// File: tb/tb_conv2_frame_scheduler.sv
// tb/tb_conv2_frame_scheduler.sv - directed self-checking bench for conv2_frame_scheduler
module tb_conv2_frame_scheduler;

   localparam int DATA_W = 96;
   localparam int OUT_W  = 16;
   localparam int RD_AW  = 8;
   localparam int WR_AW  = 9;
   localparam int WDOG   = 1023;
   localparam logic [DATA_W-1:0] JUNK = 96'hBAD0_BAD1_BAD2_BAD3_BAD4_BAD5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   conv2_frame_scheduler_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .RD_AW(RD_AW), .WR_AW(WR_AW)) bus ();

   conv2_frame_scheduler #(
      .IMG_W(13), .IMG_H(13), .KSZ(3), .OUT_CH(3),
      .DATA_W(DATA_W), .OUT_W(OUT_W), .RD_AW(RD_AW), .WR_AW(WR_AW), .WDOG(WDOG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_pass = 0, n_total = 0;
   int cyc = 0, start_cyc = 0;
   int rd_cnt, words_seen, we_cnt, done_cnt, err_cnt, slack_cnt;
   int addr_err, lag_err, data_err, rdy_err, res_err;
   int first_rd_cyc, last_rd_cyc, err_cyc, last_beat_cyc, beats_sent;
   int beat_thresh = 8, beat_limit = 363, ready_mode = 0;
   bit model_on = 1'b0, busy_at_err = 1'b0, prev_rd = 1'b0, to;
   logic [RD_AW-1:0] prev_addr = '0, exp_addr = '0;

   function automatic logic [DATA_W-1:0] fb_word(input logic [RD_AW-1:0] a);
      return {24'hC0DE00, a, a, 24'h5A5A5A, 8'h00, ~a, 16'h1234};
   endfunction

   // Feature buffer, ready pattern and conv2 result source; driven 1 time unit after each edge.
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      bus.fb_rd_data = prev_rd ? fb_word(prev_addr) : JUNK;
      if (ready_mode == 0) bus.c2_ready = 1'b1;
      else if (ready_mode == 1) bus.c2_ready = !bus.c2_ready;
      if (model_on && words_seen >= beat_thresh && beats_sent < beat_limit) begin
         bus.c2_data_out_valid = 1'b1;
         bus.c2_data_out = 16'h4000 + 16'(beats_sent);
         last_beat_cyc = cyc;
         beats_sent = beats_sent + 1;
      end else begin
         bus.c2_data_out_valid = 1'b0;
         bus.c2_data_out = '0;
      end
   end

   // Observer, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.c2_data_in_valid !== prev_rd) lag_err++;
      if (bus.c2_data_in_valid === 1'b1) begin
         words_seen++;
         if (bus.c2_data_in !== fb_word(prev_addr)) data_err++;
         if (bus.c2_ready !== 1'b1) slack_cnt++;
      end else if (bus.c2_data_in !== '0) data_err++;
      if (bus.fb_rd_en === 1'b1) begin
         if (bus.fb_rd_addr !== exp_addr) addr_err++;
         if (bus.c2_ready !== 1'b1) rdy_err++;
         if (rd_cnt == 0) first_rd_cyc = cyc;
         last_rd_cyc = cyc;
         rd_cnt++;
         exp_addr = exp_addr + 1'b1;
      end
      prev_rd = (bus.fb_rd_en === 1'b1);
      prev_addr = bus.fb_rd_addr;
      if (bus.res_we === 1'b1) begin
         if (bus.res_addr !== WR_AW'(we_cnt) || bus.res_data !== 16'h4000 + 16'(we_cnt)) res_err++;
         we_cnt++;
      end
      if (bus.done === 1'b1) done_cnt++;
      if (bus.err === 1'b1) begin
         err_cnt++;
         err_cyc = cyc;
         busy_at_err = bus.busy;
      end
   end

   task automatic clear_mon();
      @(posedge clk);
      #2;
      rd_cnt = 0; words_seen = 0; we_cnt = 0; done_cnt = 0; err_cnt = 0; slack_cnt = 0;
      addr_err = 0; lag_err = 0; data_err = 0; rdy_err = 0; res_err = 0;
      first_rd_cyc = 0; last_rd_cyc = 0; err_cyc = 0; last_beat_cyc = 0; beats_sent = 0;
      exp_addr = '0;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_end(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (done_cnt != 0 || err_cnt != 0) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0d want 0", bus.busy); else n_pass++;
      n_total++; if (bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL reset_done_err: got %0d/%0d want 0/0", bus.done, bus.err); else n_pass++;
      n_total++; if (bus.fb_rd_en !== 1'b0 || bus.fb_rd_addr !== '0) $display("FAIL reset_rd: got %0d/%0d want 0/0", bus.fb_rd_en, bus.fb_rd_addr); else n_pass++;
      n_total++; if (bus.c2_data_in_valid !== 1'b0 || bus.c2_data_in !== '0) $display("FAIL reset_c2_in: got %0d/%h want 0/0", bus.c2_data_in_valid, bus.c2_data_in); else n_pass++;
      n_total++; if (bus.res_we !== 1'b0 || bus.res_addr !== '0 || bus.res_data !== '0) $display("FAIL reset_res: got %0d/%0d/%0d want 0/0/0", bus.res_we, bus.res_addr, bus.res_data); else n_pass++;
      n_total++; if (bus.out_count !== '0) $display("FAIL reset_out_count: got %0d want 0", bus.out_count); else n_pass++;
      rst_n = 1'b1;
      clear_mon();
      repeat (20) @(posedge clk);
      #2;
      n_total++; if (rd_cnt !== 0) $display("FAIL idle_no_reads: got %0d want 0", rd_cnt); else n_pass++;
   endtask

   task automatic test_nominal();
      ready_mode = 0; beat_thresh = 8; beat_limit = 363;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      n_total++; if (bus.busy !== 1'b1) $display("FAIL nom_busy_after_start: got %0d want 1", bus.busy); else n_pass++;
      wait_end(2000, to);
      n_total++; if (to !== 1'b0) $display("FAIL nom_timeout: got %0d want 0", to); else n_pass++;
      repeat (10) @(posedge clk);
      #2;
      model_on = 1'b0;
      n_total++; if (done_cnt !== 1 || err_cnt !== 0) $display("FAIL nom_done_err: got %0d/%0d want 1/0", done_cnt, err_cnt); else n_pass++;
      n_total++; if (rd_cnt !== 169 || addr_err !== 0) $display("FAIL nom_reads: got %0d reads %0d bad addr want 169/0", rd_cnt, addr_err); else n_pass++;
      n_total++; if (first_rd_cyc !== start_cyc + 1) $display("FAIL nom_first_read: got cycle %0d want %0d", first_rd_cyc, start_cyc + 1); else n_pass++;
      n_total++; if (last_rd_cyc - first_rd_cyc !== 168) $display("FAIL nom_read_span: got %0d want 168", last_rd_cyc - first_rd_cyc); else n_pass++;
      n_total++; if (lag_err !== 0 || data_err !== 0 || words_seen !== 169) $display("FAIL nom_issue: got lag %0d data %0d words %0d want 0/0/169", lag_err, data_err, words_seen); else n_pass++;
      n_total++; if (we_cnt !== 363 || res_err !== 0) $display("FAIL nom_results: got %0d writes %0d bad want 363/0", we_cnt, res_err); else n_pass++;
      n_total++; if (bus.out_count !== 9'd363 || bus.busy !== 1'b0) $display("FAIL nom_final: got count %0d busy %0d want 363/0", bus.out_count, bus.busy); else n_pass++;
   endtask

   task automatic test_backpressure();
      ready_mode = 1; beat_thresh = 8; beat_limit = 363;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      wait_end(3000, to);
      n_total++; if (to !== 1'b0) $display("FAIL bp_timeout: got %0d want 0", to); else n_pass++;
      repeat (10) @(posedge clk);
      #2;
      model_on = 1'b0;
      ready_mode = 0;
      n_total++; if (done_cnt !== 1) $display("FAIL bp_done: got %0d want 1", done_cnt); else n_pass++;
      n_total++; if (rd_cnt !== 169 || addr_err !== 0 || rdy_err !== 0) $display("FAIL bp_reads: got %0d reads %0d addr %0d rdy want 169/0/0", rd_cnt, addr_err, rdy_err); else n_pass++;
      n_total++; if (last_rd_cyc - first_rd_cyc !== 336) $display("FAIL bp_read_span: got %0d want 336", last_rd_cyc - first_rd_cyc); else n_pass++;
      n_total++; if (words_seen !== 169 || lag_err !== 0 || data_err !== 0) $display("FAIL bp_issue: got words %0d lag %0d data %0d want 169/0/0", words_seen, lag_err, data_err); else n_pass++;
   endtask

   task automatic test_ready_drop();
      ready_mode = 2; beat_thresh = 8; beat_limit = 363;
      @(posedge clk);
      #1;
      bus.c2_ready = 1'b0;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      repeat (3) begin @(posedge clk); #1; end
      bus.c2_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.c2_ready = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      n_total++; if (rd_cnt !== 1 || rdy_err !== 0) $display("FAIL drop_one_read: got %0d reads %0d rdy want 1/0", rd_cnt, rdy_err); else n_pass++;
      n_total++; if (words_seen !== 1 || slack_cnt !== 1 || data_err !== 0 || lag_err !== 0) $display("FAIL drop_delivered: got words %0d slack %0d data %0d lag %0d want 1/1/0/0", words_seen, slack_cnt, data_err, lag_err); else n_pass++;
      ready_mode = 0;
      wait_end(2000, to);
      repeat (5) @(posedge clk);
      #2;
      model_on = 1'b0;
      n_total++; if (to !== 1'b0 || done_cnt !== 1) $display("FAIL drop_complete: got timeout %0d done %0d want 0/1", to, done_cnt); else n_pass++;
      n_total++; if (rd_cnt !== 169 || addr_err !== 0) $display("FAIL drop_reads: got %0d reads %0d bad want 169/0", rd_cnt, addr_err); else n_pass++;
   endtask

   task automatic test_watchdog();
      ready_mode = 0; beat_thresh = 150; beat_limit = 100;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      wait_end(3000, to);
      n_total++; if (to !== 1'b0) $display("FAIL wd_timeout: got %0d want 0", to); else n_pass++;
      repeat (5) @(posedge clk);
      #2;
      model_on = 1'b0;
      n_total++; if (err_cnt !== 1 || done_cnt !== 0) $display("FAIL wd_err_done: got %0d/%0d want 1/0", err_cnt, done_cnt); else n_pass++;
      n_total++; if (err_cyc - last_beat_cyc !== WDOG + 1) $display("FAIL wd_latency: got %0d want %0d", err_cyc - last_beat_cyc, WDOG + 1); else n_pass++;
      n_total++; if (busy_at_err !== 1'b0 || bus.busy !== 1'b0) $display("FAIL wd_busy: got %0d/%0d want 0/0", busy_at_err, bus.busy); else n_pass++;
      n_total++; if (bus.out_count !== 9'd100 || we_cnt !== 100 || rd_cnt !== 169) $display("FAIL wd_counts: got count %0d writes %0d reads %0d want 100/100/169", bus.out_count, we_cnt, rd_cnt); else n_pass++;
   endtask

   task automatic test_excess_and_stray_start();
      ready_mode = 0; beat_thresh = 8; beat_limit = 370;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      repeat (40) @(posedge clk);
      pulse_start();
      repeat (200) @(posedge clk);
      pulse_start();
      wait_end(1000, to);
      repeat (20) @(posedge clk);
      #2;
      model_on = 1'b0;
      n_total++; if (to !== 1'b0 || done_cnt !== 1 || err_cnt !== 0) $display("FAIL ex_done: got timeout %0d done %0d err %0d want 0/1/0", to, done_cnt, err_cnt); else n_pass++;
      n_total++; if (rd_cnt !== 169 || addr_err !== 0) $display("FAIL ex_reads: got %0d reads %0d bad want 169/0", rd_cnt, addr_err); else n_pass++;
      n_total++; if (we_cnt !== 363 || res_err !== 0) $display("FAIL ex_writes: got %0d writes %0d bad want 363/0", we_cnt, res_err); else n_pass++;
      n_total++; if (bus.out_count !== 9'd363) $display("FAIL ex_out_count: got %0d want 363", bus.out_count); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int i;
      ready_mode = 0; beat_thresh = 8; beat_limit = 363;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      for (i = 0; i < 400; i++) begin
         @(posedge clk);
         if (rd_cnt >= 50) break;
      end
      n_total++; if (rd_cnt !== 50) $display("FAIL rst_reach_50: got %0d want 50", rd_cnt); else n_pass++;
      #2;
      rst_n = 1'b0;
      #1;
      n_total++; if (bus.busy !== 1'b0 || bus.fb_rd_en !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) $display("FAIL rst_ctrl: got busy %0d rd %0d done %0d err %0d want 0", bus.busy, bus.fb_rd_en, bus.done, bus.err); else n_pass++;
      n_total++; if (bus.c2_data_in_valid !== 1'b0 || bus.c2_data_in !== '0) $display("FAIL rst_squash: got %0d/%h want 0/0", bus.c2_data_in_valid, bus.c2_data_in); else n_pass++;
      n_total++; if (bus.res_we !== 1'b0 || bus.out_count !== '0) $display("FAIL rst_res: got %0d/%0d want 0/0", bus.res_we, bus.out_count); else n_pass++;
      model_on = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      n_total++; if (done_cnt !== 0 || err_cnt !== 0) $display("FAIL rst_no_pulse: got %0d/%0d want 0/0", done_cnt, err_cnt); else n_pass++;
      rst_n = 1'b1;
      clear_mon();
      model_on = 1'b1;
      pulse_start();
      wait_end(2000, to);
      repeat (5) @(posedge clk);
      #2;
      model_on = 1'b0;
      n_total++; if (to !== 1'b0 || done_cnt !== 1) $display("FAIL rst_restart_done: got timeout %0d done %0d want 0/1", to, done_cnt); else n_pass++;
      n_total++; if (rd_cnt !== 169 || addr_err !== 0 || we_cnt !== 363) $display("FAIL rst_restart: got reads %0d bad addr %0d writes %0d want 169/0/363", rd_cnt, addr_err, we_cnt); else n_pass++;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.c2_ready = 1'b0;
      bus.fb_rd_data = '0;
      bus.c2_data_out = '0;
      bus.c2_data_out_valid = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_ready_drop();
      test_watchdog();
      test_excess_and_stray_start();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
